// File: rtl/tlul_socket_nd_pkg.sv
// TL-UL channel payload types and response integrity generator shared by the socket.
package tlul_socket_nd_pkg;

  localparam int unsigned AddrW  = 32;
  localparam int unsigned DataW  = 32;
  localparam int unsigned SrcW   = 8;
  localparam int unsigned SizeW  = 2;
  localparam int unsigned OpW    = 3;
  localparam int unsigned DUserW = 14;

  localparam logic [OpW-1:0] OpPutFullData    = 3'h0;
  localparam logic [OpW-1:0] OpPutPartialData = 3'h1;
  localparam logic [OpW-1:0] OpGet            = 3'h4;
  localparam logic [OpW-1:0] OpAccessAck      = 3'h0;
  localparam logic [OpW-1:0] OpAccessAckData  = 3'h1;

  typedef struct packed {
    logic               a_valid;
    logic [OpW-1:0]     a_opcode;
    logic [2:0]         a_param;
    logic [SizeW-1:0]   a_size;
    logic [SrcW-1:0]    a_source;
    logic [AddrW-1:0]   a_address;
    logic [DataW/8-1:0] a_mask;
    logic [DataW-1:0]   a_data;
    logic               d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [OpW-1:0]    d_opcode;
    logic [2:0]        d_param;
    logic [SizeW-1:0]  d_size;
    logic [SrcW-1:0]   d_source;
    logic              d_sink;
    logic [DataW-1:0]  d_data;
    logic [DUserW-1:0] d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  // Response integrity: {7 bits over response metadata, 7 bits over data}.
  function automatic logic [DUserW-1:0] tl_rsp_intg(
    input logic [OpW-1:0]   opcode,
    input logic [SizeW-1:0] size,
    input logic [SrcW-1:0]  source,
    input logic             error,
    input logic [DataW-1:0] data
  );
    logic [13:0] meta;
    logic [6:0]  rsp_intg;
    logic [6:0]  data_intg;
    meta = {opcode, size, source, error};
    for (int k = 0; k < 7; k++) begin
      rsp_intg[k]  = meta[k] ^ meta[k+7];
      data_intg[k] = ^data[4*k +: 4];
    end
    data_intg[6] = data_intg[6] ^ (^data[31:28]);
    return {rsp_intg, data_intg};
  endfunction

endpackage

// File: rtl/tlul_socket_nd_if.sv
// Host and per-device TL-UL channels of the 1:N socket.
interface tlul_socket_nd_if #(
  parameter int unsigned NumDev = 3
) ();
  import tlul_socket_nd_pkg::*;

  tl_h2d_t              tl_h_i;
  tl_d2h_t              tl_h_o;
  tl_h2d_t [NumDev-1:0] tl_d_o;
  tl_d2h_t [NumDev-1:0] tl_d_i;

  // Socket side.
  modport slave (
    input  tl_h_i,
    input  tl_d_i,
    output tl_h_o,
    output tl_d_o
  );

  // Host and device environment side.
  modport master (
    output tl_h_i,
    output tl_d_i,
    input  tl_h_o,
    input  tl_d_o
  );
endinterface

// File: rtl/tlul_socket_nd.sv
// TL-UL 1-host to N-device socket: address decode, in-order outstanding tracking,
// and an internal error responder for unmapped addresses.
module tlul_socket_nd
  import tlul_socket_nd_pkg::*;
#(
  parameter int unsigned            NumDev         = 3,
  parameter int unsigned            MaxOutstanding = 4,
  parameter logic [NumDev*32-1:0]   DevBase        = '0,
  parameter logic [NumDev*32-1:0]   DevMask        = '0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  tlul_socket_nd_if.slave                      bus,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 decode_err_o
);

  localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);
  localparam int unsigned TgtW   = $clog2(NumDev + 1);
  localparam logic [TgtW-1:0] ErrTgt = TgtW'(NumDev);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  tl_h2d_t              h_req;
  tl_d2h_t [NumDev-1:0] dev_rsp;
  tl_h2d_t [NumDev-1:0] dev_req;
  tl_d2h_t              host_rsp;
  tl_d2h_t              err_rsp;
  tl_d2h_t              pend_rsp;

  logic [CntW-1:0]  count_q, count_d;
  logic [TgtW-1:0]  pend_q, pend_d;
  logic             err_valid_q, err_valid_d;
  logic [OpW-1:0]   err_opcode_q, err_opcode_d;
  logic [SrcW-1:0]  err_source_q, err_source_d;
  logic [SizeW-1:0] err_size_q, err_size_d;

  logic [TgtW-1:0]  tgt;
  logic             tgt_a_ready;
  logic             d_valid_c;
  logic             rsp_hs_c;
  logic             issue_ok;
  logic             a_ready_c;
  logic             accept_c;
  logic             err_accept_c;
  logic             err_done_c;

  assign h_req      = bus.tl_h_i;
  assign dev_rsp    = bus.tl_d_i;
  assign bus.tl_d_o = dev_req;
  assign bus.tl_h_o = host_rsp;

  // Address decode; iterating downward lets the lowest matching index win.
  always_comb begin
    tgt = ErrTgt;
    for (int i = int'(NumDev) - 1; i >= 0; i--) begin
      if ((h_req.a_address & DevMask[32*i +: 32]) == DevBase[32*i +: 32]) begin
        tgt = TgtW'(i);
      end
    end
  end

  // Error responder response payload built from the latched request fields.
  always_comb begin
    err_rsp          = '0;
    err_rsp.d_valid  = err_valid_q;
    err_rsp.d_opcode = (err_opcode_q == OpGet) ? OpAccessAckData : OpAccessAck;
    err_rsp.d_size   = err_size_q;
    err_rsp.d_source = err_source_q;
    err_rsp.d_data   = '1;
    err_rsp.d_error  = 1'b1;
    err_rsp.d_user   = tl_rsp_intg(err_rsp.d_opcode, err_size_q, err_source_q,
                                   1'b1, err_rsp.d_data);
    err_rsp.a_ready  = ~err_valid_q;
  end

  // Response source follows the pending target.
  always_comb begin
    pend_rsp = err_rsp;
    for (int i = 0; i < int'(NumDev); i++) begin
      if (pend_q == TgtW'(i)) pend_rsp = dev_rsp[i];
    end
  end

  assign d_valid_c = (count_q != '0) && pend_rsp.d_valid;
  assign rsp_hs_c  = d_valid_c && h_req.d_ready;

  // Ready of the decoded target; the error buffer frees in its own response handshake.
  always_comb begin
    tgt_a_ready = ~err_valid_q | rsp_hs_c;
    for (int i = 0; i < int'(NumDev); i++) begin
      if (tgt == TgtW'(i)) tgt_a_ready = dev_rsp[i].a_ready;
    end
  end

  // Issue gating keeps responses in order: a new target waits until the socket drains.
  // A response retiring this cycle frees a slot for a same-cycle issue at the limit.
  assign issue_ok     = rst_ni && ((count_q < CntMax) || rsp_hs_c) &&
                        ((count_q == '0) || (tgt == pend_q));
  assign a_ready_c    = issue_ok && tgt_a_ready;
  assign accept_c     = h_req.a_valid && a_ready_c;
  assign err_accept_c = accept_c && (tgt == ErrTgt);
  assign err_done_c   = rsp_hs_c && (pend_q == ErrTgt);

  // Request fan-out and d_ready steering toward the devices.
  always_comb begin
    for (int i = 0; i < int'(NumDev); i++) begin
      dev_req[i]         = h_req;
      dev_req[i].a_valid = h_req.a_valid && issue_ok && (tgt == TgtW'(i));
      dev_req[i].d_ready = ((count_q != '0) && (pend_q == TgtW'(i))) ? h_req.d_ready : 1'b1;
    end
  end

  // Host response channel.
  always_comb begin
    host_rsp         = pend_rsp;
    host_rsp.d_valid = d_valid_c;
    host_rsp.a_ready = a_ready_c;
  end

  // Next-state for the outstanding counter, pending target and error buffer.
  always_comb begin
    count_d      = count_q;
    pend_d       = pend_q;
    err_valid_d  = err_valid_q;
    err_opcode_d = err_opcode_q;
    err_source_d = err_source_q;
    err_size_d   = err_size_q;
    if (accept_c && !rsp_hs_c) begin
      count_d = count_q + CntW'(1);
    end else if (!accept_c && rsp_hs_c) begin
      count_d = count_q - CntW'(1);
    end
    if (accept_c) pend_d = tgt;
    if (err_accept_c) begin
      err_valid_d  = 1'b1;
      err_opcode_d = h_req.a_opcode;
      err_source_d = h_req.a_source;
      err_size_d   = h_req.a_size;
    end else if (err_done_c) begin
      err_valid_d  = 1'b0;
    end
  end

  // State registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q      <= '0;
      pend_q       <= '0;
      err_valid_q  <= 1'b0;
      err_opcode_q <= '0;
      err_source_q <= '0;
      err_size_q   <= '0;
    end else begin
      count_q      <= count_d;
      pend_q       <= pend_d;
      err_valid_q  <= err_valid_d;
      err_opcode_q <= err_opcode_d;
      err_source_q <= err_source_d;
      err_size_q   <= err_size_d;
    end
  end

  assign outstanding_o = count_q;
  assign decode_err_o  = err_accept_c;

endmodule

// File: tb/tb_tlul_socket_nd.sv
// Directed bench for tlul_socket_nd: routing, error responder, outstanding limit,
// ordering stall, overlapping windows and mid-operation reset.
module tb_tlul_socket_nd;
  import tlul_socket_nd_pkg::*;

  localparam logic [95:0] Base   = {32'h4001_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [95:0] Mask   = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_E000};
  localparam logic [95:0] BaseOv = {32'h4001_0000, 32'h4000_0000, 32'h4001_0000};
  localparam logic [95:0] MaskOv = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000};

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [2:0] out_cnt, out_cnt_ov;
  logic       derr, derr_ov;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk_i = ~clk_i;

  tlul_socket_nd_if #(.NumDev(3)) bus ();
  tlul_socket_nd_if #(.NumDev(3)) bus_ov ();

  tlul_socket_nd #(.NumDev(3), .MaxOutstanding(4), .DevBase(Base), .DevMask(Mask)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus.slave),
    .outstanding_o(out_cnt), .decode_err_o(derr)
  );

  tlul_socket_nd #(.NumDev(3), .MaxOutstanding(4), .DevBase(BaseOv), .DevMask(MaskOv)) u_dut_ov (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_ov.slave),
    .outstanding_o(out_cnt_ov), .decode_err_o(derr_ov)
  );

  function automatic logic [2:0] av();
    return {bus.tl_d_o[2].a_valid, bus.tl_d_o[1].a_valid, bus.tl_d_o[0].a_valid};
  endfunction

  function automatic logic [2:0] av_ov();
    return {bus_ov.tl_d_o[2].a_valid, bus_ov.tl_d_o[1].a_valid, bus_ov.tl_d_o[0].a_valid};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic host_req(input logic v, input logic [2:0] op, input logic [31:0] addr,
                          input logic [7:0] src);
    bus.tl_h_i.a_valid   = v;
    bus.tl_h_i.a_opcode  = op;
    bus.tl_h_i.a_param   = 3'h0;
    bus.tl_h_i.a_size    = 2'd2;
    bus.tl_h_i.a_source  = src;
    bus.tl_h_i.a_address = addr;
    bus.tl_h_i.a_mask    = 4'hF;
    bus.tl_h_i.a_data    = 32'h0;
  endtask

  task automatic dev_idle();
    for (int k = 0; k < 3; k++) begin
      bus.tl_d_i[k]            = '0;
      bus.tl_d_i[k].a_ready    = 1'b1;
      bus_ov.tl_d_i[k]         = '0;
      bus_ov.tl_d_i[k].a_ready = 1'b1;
    end
  endtask

  task automatic dev_respond(input int k, input logic [31:0] data, input logic [7:0] src);
    bus.tl_d_i[k].d_valid  = 1'b1;
    bus.tl_d_i[k].d_opcode = OpAccessAckData;
    bus.tl_d_i[k].d_size   = 2'd2;
    bus.tl_d_i[k].d_source = src;
    bus.tl_d_i[k].d_data   = data;
  endtask

  task automatic test_reset();
    host_req(1'b1, OpGet, 32'h0000_0100, 8'h01);
    #1;
    n_cmp++; if (out_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", out_cnt); end
    n_cmp++; if (derr !== 1'b0) begin n_err++; $display("FAIL reset_derr: got %b expected 0", derr); end
    n_cmp++; if (bus.tl_h_o.d_valid !== 1'b0) begin n_err++; $display("FAIL reset_dvalid: got %b expected 0", bus.tl_h_o.d_valid); end
    n_cmp++; if (bus.tl_h_o.a_ready !== 1'b0) begin n_err++; $display("FAIL reset_aready: got %b expected 0", bus.tl_h_o.a_ready); end
    n_cmp++; if (av() !== 3'b000) begin n_err++; $display("FAIL reset_avalid: got %b expected 000", av()); end
    host_req(1'b0, OpGet, 32'h0, 8'h0);
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_single_get();
    bus.tl_h_i.d_ready = 1'b1;
    host_req(1'b1, OpGet, 32'h4000_0010, 8'h11);
    #1;
    n_cmp++; if (av() !== 3'b010) begin n_err++; $display("FAIL get_route: got %b expected 010", av()); end
    n_cmp++; if (bus.tl_h_o.a_ready !== 1'b1) begin n_err++; $display("FAIL get_aready: got %b expected 1", bus.tl_h_o.a_ready); end
    n_cmp++; if (out_cnt !== 3'd0) begin n_err++; $display("FAIL get_cnt0: got %0d expected 0", out_cnt); end
    tick();
    host_req(1'b0, OpGet, 32'h0, 8'h0);
    dev_respond(1, 32'hCAFE_0001, 8'h11);
    #1;
    n_cmp++; if (out_cnt !== 3'd1) begin n_err++; $display("FAIL get_cnt1: got %0d expected 1", out_cnt); end
    n_cmp++; if ({bus.tl_h_o.d_valid, bus.tl_h_o.d_data, bus.tl_h_o.d_source} !== {1'b1, 32'hCAFE_0001, 8'h11}) begin
      n_err++; $display("FAIL get_rsp: got v=%b data=%h src=%h expected v=1 data=cafe0001 src=11",
                        bus.tl_h_o.d_valid, bus.tl_h_o.d_data, bus.tl_h_o.d_source);
    end
    tick();
    dev_idle();
    #1;
    n_cmp++; if (out_cnt !== 3'd0) begin n_err++; $display("FAIL get_cnt_end: got %0d expected 0", out_cnt); end
    n_cmp++; if (bus.tl_h_o.d_valid !== 1'b0) begin n_err++; $display("FAIL get_dvalid_end: got %b expected 0", bus.tl_h_o.d_valid); end
  endtask

  task automatic test_decode_err();
    bus.tl_h_i.d_ready = 1'b0;
    host_req(1'b1, OpGet, 32'h8000_0000, 8'h5A);
    #1;
    n_cmp++; if (derr !== 1'b1) begin n_err++; $display("FAIL err_pulse: got %b expected 1", derr); end
    n_cmp++; if (av() !== 3'b000) begin n_err++; $display("FAIL err_no_dev: got %b expected 000", av()); end
    n_cmp++; if (bus.tl_h_o.a_ready !== 1'b1) begin n_err++; $display("FAIL err_aready: got %b expected 1", bus.tl_h_o.a_ready); end
    n_cmp++; if (bus.tl_h_o.d_valid !== 1'b0) begin n_err++; $display("FAIL err_dvalid_early: got %b expected 0", bus.tl_h_o.d_valid); end
    tick();
    host_req(1'b0, OpGet, 32'h0, 8'h0);
    #1;
    n_cmp++; if (derr !== 1'b0) begin n_err++; $display("FAIL err_pulse_once: got %b expected 0", derr); end
    n_cmp++; if (out_cnt !== 3'd1) begin n_err++; $display("FAIL err_cnt: got %0d expected 1", out_cnt); end
    n_cmp++; if ({bus.tl_h_o.d_valid, bus.tl_h_o.d_error} !== 2'b11) begin
      n_err++; $display("FAIL err_valid_error: got %b%b expected 11", bus.tl_h_o.d_valid, bus.tl_h_o.d_error);
    end
    n_cmp++; if (bus.tl_h_o.d_data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL err_data: got %h expected ffffffff", bus.tl_h_o.d_data); end
    n_cmp++; if ({bus.tl_h_o.d_opcode, bus.tl_h_o.d_source, bus.tl_h_o.d_size} !== {OpAccessAckData, 8'h5A, 2'd2}) begin
      n_err++; $display("FAIL err_fields: got op=%0d src=%h size=%0d expected op=1 src=5a size=2",
                        bus.tl_h_o.d_opcode, bus.tl_h_o.d_source, bus.tl_h_o.d_size);
    end
    bus.tl_h_i.d_ready = 1'b1;
    host_req(1'b1, OpPutFullData, 32'h9000_0000, 8'h33);
    #1;
    n_cmp++; if (bus.tl_h_o.a_ready !== 1'b1) begin n_err++; $display("FAIL err_b2b_aready: got %b expected 1", bus.tl_h_o.a_ready); end
    tick();
    host_req(1'b0, OpGet, 32'h0, 8'h0);
    bus.tl_h_i.d_ready = 1'b0;
    #1;
    n_cmp++; if (out_cnt !== 3'd1) begin n_err++; $display("FAIL err_b2b_cnt: got %0d expected 1", out_cnt); end
    n_cmp++; if ({bus.tl_h_o.d_valid, bus.tl_h_o.d_opcode, bus.tl_h_o.d_source} !== {1'b1, OpAccessAck, 8'h33}) begin
      n_err++; $display("FAIL err_b2b_rsp: got v=%b op=%0d src=%h expected v=1 op=0 src=33",
                        bus.tl_h_o.d_valid, bus.tl_h_o.d_opcode, bus.tl_h_o.d_source);
    end
    bus.tl_h_i.d_ready = 1'b1;
    tick();
    #1;
    n_cmp++; if (out_cnt !== 3'd0) begin n_err++; $display("FAIL err_cnt_end: got %0d expected 0", out_cnt); end
    n_cmp++; if (bus.tl_h_o.d_valid !== 1'b0) begin n_err++; $display("FAIL err_dvalid_end: got %b expected 0", bus.tl_h_o.d_valid); end
  endtask

  task automatic test_max_outstanding();
    bus.tl_h_i.d_ready = 1'b1;
    host_req(1'b1, OpGet, 32'h0000_0100, 8'h20);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if ({bus.tl_h_o.a_ready, out_cnt} !== {1'b1, 3'(k)}) begin
        n_err++; $display("FAIL max_fill%0d: got rdy=%b cnt=%0d expected rdy=1 cnt=%0d", k, bus.tl_h_o.a_ready, out_cnt, k);
      end
      tick();
    end
    #1;
    n_cmp++; if (out_cnt !== 3'd4) begin n_err++; $display("FAIL max_cnt_full: got %0d expected 4", out_cnt); end
    n_cmp++; if (bus.tl_h_o.a_ready !== 1'b0) begin n_err++; $display("FAIL max_stall: got %b expected 0", bus.tl_h_o.a_ready); end
    n_cmp++; if (av() !== 3'b000) begin n_err++; $display("FAIL max_avalid: got %b expected 000", av()); end
    dev_respond(0, 32'h1234_5678, 8'h20);
    #1;
    n_cmp++; if ({bus.tl_h_o.a_ready, av()} !== {1'b1, 3'b001}) begin
      n_err++; $display("FAIL max_release: got rdy=%b av=%b expected rdy=1 av=001", bus.tl_h_o.a_ready, av());
    end
    tick();
    #1;
    n_cmp++; if (out_cnt !== 3'd4) begin n_err++; $display("FAIL max_cnt_hold: got %0d expected 4", out_cnt); end
    host_req(1'b0, OpGet, 32'h0, 8'h0);
    repeat (4) tick();
    dev_idle();
    #1;
    n_cmp++; if (out_cnt !== 3'd0) begin n_err++; $display("FAIL max_drain: got %0d expected 0", out_cnt); end
  endtask

  task automatic test_order_stall();
    bus.tl_h_i.d_ready = 1'b1;
    host_req(1'b1, OpGet, 32'h0000_0200, 8'h30);
    tick();
    host_req(1'b1, OpGet, 32'h4001_0004, 8'h31);
    #1;
    n_cmp++; if (out_cnt !== 3'd1) begin n_err++; $display("FAIL order_cnt: got %0d expected 1", out_cnt); end
    n_cmp++; if ({bus.tl_h_o.a_ready, bus.tl_d_o[2].a_valid} !== 2'b00) begin
      n_err++; $display("FAIL order_stall: got rdy=%b av2=%b expected 0 0", bus.tl_h_o.a_ready, bus.tl_d_o[2].a_valid);
    end
    tick();
    dev_respond(0, 32'h0000_00AA, 8'h30);
    #1;
    n_cmp++; if (bus.tl_h_o.a_ready !== 1'b0) begin n_err++; $display("FAIL order_stall_rsp: got %b expected 0", bus.tl_h_o.a_ready); end
    tick();
    dev_idle();
    #1;
    n_cmp++; if ({out_cnt, bus.tl_h_o.a_ready, av()} !== {3'd0, 1'b1, 3'b100}) begin
      n_err++; $display("FAIL order_issue: got cnt=%0d rdy=%b av=%b expected cnt=0 rdy=1 av=100", out_cnt, bus.tl_h_o.a_ready, av());
    end
    tick();
    host_req(1'b0, OpGet, 32'h0, 8'h0);
    dev_respond(2, 32'h0000_00BB, 8'h31);
    #1;
    n_cmp++; if ({bus.tl_h_o.d_valid, bus.tl_h_o.d_data} !== {1'b1, 32'h0000_00BB}) begin
      n_err++; $display("FAIL order_rsp: got v=%b data=%h expected v=1 data=000000bb", bus.tl_h_o.d_valid, bus.tl_h_o.d_data);
    end
    tick();
    dev_idle();
    #1;
    n_cmp++; if (out_cnt !== 3'd0) begin n_err++; $display("FAIL order_cnt_end: got %0d expected 0", out_cnt); end
  endtask

  task automatic test_overlap();
    bus_ov.tl_h_i           = '0;
    bus_ov.tl_h_i.a_valid   = 1'b1;
    bus_ov.tl_h_i.a_opcode  = OpGet;
    bus_ov.tl_h_i.a_address = 32'h4001_0020;
    #1;
    n_cmp++; if (av_ov() !== 3'b001) begin n_err++; $display("FAIL overlap_low: got %b expected 001", av_ov()); end
    bus_ov.tl_h_i.a_address = 32'h4000_0040;
    #1;
    n_cmp++; if (av_ov() !== 3'b010) begin n_err++; $display("FAIL overlap_dev1: got %b expected 010", av_ov()); end
    bus_ov.tl_h_i = '0;
  endtask

  task automatic test_mid_reset();
    bus.tl_h_i.d_ready = 1'b0;
    host_req(1'b1, OpGet, 32'h0000_0300, 8'h40);
    repeat (3) tick();
    host_req(1'b0, OpGet, 32'h0, 8'h0);
    dev_respond(0, 32'h0000_0055, 8'h40);
    #1;
    n_cmp++; if ({out_cnt, bus.tl_h_o.d_valid} !== {3'd3, 1'b1}) begin
      n_err++; $display("FAIL rst_pre: got cnt=%0d dv=%b expected cnt=3 dv=1", out_cnt, bus.tl_h_o.d_valid);
    end
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (out_cnt !== 3'd0) begin n_err++; $display("FAIL rst_async_cnt: got %0d expected 0", out_cnt); end
    n_cmp++; if (bus.tl_h_o.d_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_dvalid: got %b expected 0", bus.tl_h_o.d_valid); end
    tick();
    tick();
    rst_ni = 1'b1;
    dev_idle();
    bus.tl_h_i.d_ready = 1'b1;
    host_req(1'b1, OpGet, 32'h4000_0020, 8'h41);
    #1;
    n_cmp++; if ({bus.tl_h_o.a_ready, av()} !== {1'b1, 3'b010}) begin
      n_err++; $display("FAIL rst_reissue: got rdy=%b av=%b expected rdy=1 av=010", bus.tl_h_o.a_ready, av());
    end
    tick();
    host_req(1'b0, OpGet, 32'h0, 8'h0);
    #1;
    n_cmp++; if (out_cnt !== 3'd1) begin n_err++; $display("FAIL rst_cnt_after: got %0d expected 1", out_cnt); end
    dev_respond(1, 32'h0000_0066, 8'h41);
    tick();
    dev_idle();
    #1;
    n_cmp++; if (out_cnt !== 3'd0) begin n_err++; $display("FAIL rst_cnt_end: got %0d expected 0", out_cnt); end
  endtask

  initial begin
    bus.tl_h_i    = '0;
    bus_ov.tl_h_i = '0;
    dev_idle();
    rst_ni = 1'b0;
    tick();
    test_reset();
    test_single_get();
    test_decode_err();
    test_max_outstanding();
    test_order_stall();
    test_overlap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
